alu_seq: RTL and testbench

Parametrised WIDTH-bit ALU executing the team's MIPS function-code set (AND, OR, NOR, ADD, SUB, SLT) in one cycle, plus an iterative unsigned multiply (MULTU) using one shift-add step per cycle. It replaces the chain of 1-bit ALU slices in the datapath. It exposes a start/done handshake so the control unit can stall on multi-cycle operations. Results, flags and the error bit are registered and held until the next completion.

---
 rtl/alu_seq.sv | 146 ++++++++++++++
 tb/tb_alu_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// MIPS-style ALU: AND/OR/NOR/ADD/SUB/SLT in one cycle, MULTU by iterative shift-add.
// Start/done handshake; results and flags are registered and held until the next completion.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_MULTU = 6'd25;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             err;
  } alu_out_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] mplier_nx;
  alu_out_t         alu_now;

  // SUB and SLT share the adder with B inverted and carry-in set
  function automatic alu_out_t alu_eval(input logic [5:0] f,
                                        input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] yop;
    logic signed [WIDTH-1:0] sum;
    logic                    ovf;
    alu_out_t                o;
    o   = '0;
    yop = (f == F_ADD) ? y : ~y;
    sum = x + yop + {{(WIDTH-1){1'b0}}, (f != F_ADD)};
    ovf = (x[WIDTH-1] == yop[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    case (f)
      F_AND:        o.res = x & y;
      F_OR:         o.res = x | y;
      F_NOR:        o.res = ~(x | y);
      F_ADD, F_SUB: begin
        o.res = sum;
        o.ovf = ovf;
      end
      F_SLT:        o.res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      F_MULTU:      o.res = '0;
      default:      o.err = 1'b1;
    endcase
    return o;
  endfunction

  assign alu_now = alu_eval(funct, a, b);

  always_comb begin
    step_sum  = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_nx    = step_sum[WIDTH:1];
    mplier_nx = {step_sum[0], mplier[WIDTH-1:1]};
  end

  // multiplier datapath: product low half shifts into mplier as it retires
  always_ff @(posedge clk) begin
    if (state == IDLE && start && funct == F_MULTU) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (state == MUL) begin
      acc    <= acc_nx;
      mplier <= mplier_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (funct == F_MULTU) begin
              count <= CW'(WIDTH);
              busy  <= 1'b1;
              state <= MUL;
            end else begin
              result    <= alu_now.res;
              result_hi <= '0;
              zero      <= (alu_now.res == '0);
              overflow  <= alu_now.ovf;
              err       <= alu_now.err;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        MUL: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            result_hi <= acc_nx;
            result    <= mplier_nx;
            zero      <= ({acc_nx, mplier_nx} == '0);
            overflow  <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32: expected results queued at issue, popped at done.
module tb_alu_seq;

  localparam int W = 32;
  localparam logic [5:0] F_AND = 6'd36, F_OR = 6'd37, F_NOR = 6'd39, F_ADD = 6'd32;
  localparam logic [5:0] F_SUB = 6'd34, F_SLT = 6'd42, F_MULTU = 6'd25;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   funct = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, zero, overflow, err;
  logic [W-1:0] result, result_hi;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         ovf;
    logic         err;
  } exp_t;

  typedef struct {
    logic [5:0]   f;
    logic [W-1:0] a, b, res;
    logic         z, ovf, err;
  } vec_t;

  typedef struct {
    logic [W-1:0] a, b, hi, res;
    logic         z;
    int           glitch;
  } mvec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero(zero), .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t           m;
    longint         s;
    logic [2*W-1:0] p;
    m = '0;
    case (f)
      F_AND: m.res = x & y;
      F_OR:  m.res = x | y;
      F_NOR: m.res = ~(x | y);
      F_ADD: begin
        s     = longint'($signed(x)) + longint'($signed(y));
        m.res = x + y;
        m.ovf = (s > SMAX) || (s < SMIN);
      end
      F_SUB: begin
        s     = longint'($signed(x)) - longint'($signed(y));
        m.res = x - y;
        m.ovf = (s > SMAX) || (s < SMIN);
      end
      F_SLT: m.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      F_MULTU: begin
        p     = {32'b0, x} * {32'b0, y};
        m.res = p[W-1:0];
        m.hi  = p[2*W-1:W];
      end
      default: m.err = 1'b1;
    endcase
    m.z = (m.res == '0) && (m.hi == '0);
    return m;
  endfunction

  // Issue one op, then wait (bounded) for done; records latency, busy cycles and hazards.
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int glitch, output int lat, output int bcnt,
                        output bit both, output bit moved);
    logic [W-1:0] held;
    @(negedge clk);
    funct = f; a = x; b = y; start = 1'b1;
    sb.push_back(model(f, x, y));
    @(negedge clk);
    start = 1'b0; a = ~x; b = ~y; funct = F_AND;
    held = result;
    lat = 1; bcnt = 0; both = 1'b0; moved = 1'b0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      if (done && busy) both = 1'b1;
      if (result !== held) moved = 1'b1;
      if (lat == glitch) begin
        start = 1'b1; funct = F_ADD; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    if (done && busy) both = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    int   lat, bcnt, seen;
    bit   both, moved;
    exp_t e;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, result, result_hi, zero, overflow, err} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h hi=%h z=%b o=%b e=%b want all 0",
               busy, done, result, result_hi, zero, overflow, err);
    end
    rst = 1'b0;
    run_op(F_NOR, 32'd0, 32'd0, -1, lat, bcnt, both, moved);
    e = sb.pop_front();
    total++;
    if (!done || result !== 32'hFFFF_FFFF || result !== e.res) begin
      bad++;
      $display("FAIL nor_zero: got done=%b res=%h want done=1 res=ffffffff", done, result);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, result, result_hi, zero, overflow, err} !== '0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b done=%b res=%h hi=%h z=%b o=%b e=%b want all 0",
               busy, done, result, result_hi, zero, overflow, err);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL idle_no_done: got %0d done pulses want 0", seen);
    end
  endtask

  task automatic test_alu_ops();
    int   lat, bcnt;
    bit   both, moved;
    exp_t e;
    vec_t v[16] = '{
      '{F_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0, 1'b0},
      '{F_OR,  32'h1234_5678, 32'h0F0F_0000, 32'h1F3F_5678, 1'b0, 1'b0, 1'b0},
      '{F_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0},
      '{F_NOR, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0},
      '{F_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0},
      '{F_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0},
      '{F_ADD, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0, 1'b0, 1'b0},
      '{F_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0},
      '{F_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0},
      '{F_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0},
      '{F_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0},
      '{F_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0},
      '{F_SLT, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0},
      '{F_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0},
      '{6'd0,  32'h0000_1234, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
      '{6'd63, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1}
    };
    for (int i = 0; i < 16; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, -1, lat, bcnt, both, moved);
      e = sb.pop_front();
      total++;
      if (!done || {result, result_hi, zero, overflow, err} !== e) begin
        bad++;
        $display("FAIL op%0d_sb: got done=%b res=%h hi=%h z=%b o=%b e=%b want res=%h hi=%h z=%b o=%b e=%b",
                 i, done, result, result_hi, zero, overflow, err, e.res, e.hi, e.z, e.ovf, e.err);
      end
      total++;
      if (lat != 1 || bcnt != 0 || result !== v[i].res || zero !== v[i].z ||
          overflow !== v[i].ovf || err !== v[i].err) begin
        bad++;
        $display("FAIL op%0d_const: got lat=%0d busy=%0d res=%h z=%b o=%b e=%b want lat=1 busy=0 res=%h z=%b o=%b e=%b",
                 i, lat, bcnt, result, zero, overflow, err, v[i].res, v[i].z, v[i].ovf, v[i].err);
      end
    end
  endtask

  task automatic test_multu();
    int    lat, bcnt, extra;
    bit    both, moved;
    exp_t  e;
    mvec_t v[3] = '{
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, -1},
      '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1, 5},
      '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 31}
    };
    for (int i = 0; i < 3; i++) begin
      run_op(F_MULTU, v[i].a, v[i].b, v[i].glitch, lat, bcnt, both, moved);
      e = sb.pop_front();
      total++;
      if (!done || {result, result_hi, zero, overflow, err} !== e ||
          result_hi !== v[i].hi || result !== v[i].res || zero !== v[i].z) begin
        bad++;
        $display("FAIL mul%0d_value: got done=%b hi=%h res=%h z=%b o=%b e=%b want hi=%h res=%h z=%b o=0 e=0",
                 i, done, result_hi, result, zero, overflow, err, v[i].hi, v[i].res, v[i].z);
      end
      total++;
      if (lat != 33 || bcnt != 32 || both || moved) begin
        bad++;
        $display("FAIL mul%0d_timing: got lat=%0d busy_cycles=%0d overlap=%b held_changed=%b want 33 32 0 0",
                 i, lat, bcnt, both, moved);
      end
      extra = 0;
      repeat (4) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      total++;
      if (extra != 0) begin
        bad++;
        $display("FAIL mul%0d_quiet: got %0d cycles with done/busy after completion want 0", i, extra);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [5:0] fs[4] = '{F_ADD, F_SLT, F_OR, F_SUB};
    logic [W-1:0] as[4] = '{32'h0000_0010, 32'hFFFF_FFF0, 32'hA5A5_0000, 32'h0000_0100};
    logic [W-1:0] bs[4] = '{32'h0000_0020, 32'h0000_0003, 32'h0000_5A5A, 32'h0000_0001};
    @(negedge clk);
    funct = fs[0]; a = as[0]; b = bs[0]; start = 1'b1;
    sb.push_back(model(fs[0], as[0], bs[0]));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (done !== 1'b1 || {result, result_hi, zero, overflow, err} !== e) begin
        bad++;
        $display("FAIL b2b%0d_done: got done=%b res=%h z=%b o=%b want done=1 res=%h z=%b o=%b",
                 k, done, result, zero, overflow, e.res, e.z, e.ovf);
      end
      if (k < 3) begin
        funct = fs[k+1]; a = as[k+1]; b = bs[k+1];
        sb.push_back(model(fs[k+1], as[k+1], bs[k+1]));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL b2b%0d_gap: got done=%b busy=%b want 0 0", k, done, busy);
      end
    end
  endtask

  task automatic test_reset_midop();
    int   lat, bcnt, seen;
    bit   both, moved;
    exp_t e;
    @(negedge clk);
    funct = F_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    total++;
    if (busy !== 1'b1 || result === '0) begin
      bad++;
      $display("FAIL midop_busy: got busy=%b res=%h want busy=1 res=held nonzero", busy, result);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, result, result_hi, zero, overflow, err} !== '0) begin
      bad++;
      $display("FAIL midop_reset: got busy=%b done=%b res=%h hi=%h z=%b o=%b e=%b want all 0",
               busy, done, result, result_hi, zero, overflow, err);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midop_abort: got %0d cycles with done/busy want 0", seen);
    end
    run_op(F_ADD, 32'd2, 32'd3, -1, lat, bcnt, both, moved);
    e = sb.pop_front();
    total++;
    if (!done || result !== 32'd5 || {result, result_hi, zero, overflow, err} !== e) begin
      bad++;
      $display("FAIL post_reset_add: got done=%b res=%h want done=1 res=00000005", done, result);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_multu();
    test_back_to_back();
    test_reset_midop();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
